// File: rtl/poly_chord_synth.sv
// Polyphonic tone generator: per-voice phase/step/duration state, one mixed PCM
// sample per codec frame, rendered by time-sharing a registered sine ROM.
module poly_chord_synth #(
    parameter int VOICES     = 4,
    parameter int SAMPLE_W   = 16,
    parameter int PHASE_W    = 22,
    parameter int ROM_ADDR_W = 10,
    parameter int DUR_W      = 20,
    parameter int MIX_MODE   = 0
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             new_frame,
    input  logic                                             play,
    input  logic                                             note_valid,
    output logic                                             note_ready,
    input  logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0]   note_voice,
    input  logic [PHASE_W-1:0]                               note_step,
    input  logic [DUR_W-1:0]                                 note_dur,
    output logic [ROM_ADDR_W-1:0]                            rom_addr,
    input  logic [SAMPLE_W-1:0]                              rom_data,
    output logic [SAMPLE_W-1:0]                              sample_out,
    output logic                                             sample_valid,
    output logic [VOICES-1:0]                                active,
    output logic                                             frame_overrun
);

    localparam int VW    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int LOG2V = $clog2(VOICES);
    localparam int ACC_W = SAMPLE_W + LOG2V;
    localparam int CW    = VW + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(VOICES);
    localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    state_t state_r, state_next_s;

    logic [PHASE_W-1:0]       phase_r  [VOICES];
    logic [PHASE_W-1:0]       step_r   [VOICES];
    logic [DUR_W-1:0]         remain_r [VOICES];
    logic [CW-1:0]            cnt_r;
    logic [CW-1:0]            next_cnt_s;
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic signed [ACC_W-1:0]  contrib_s;
    logic [VW-1:0]            acc_idx_s;
    logic [VW-1:0]            rd_idx_s;
    logic                     load_s;
    logic                     frame_start_s;
    logic                     acc_en_s;
    logic                     last_s;
    logic                     voice_adv_s;
    logic                     voice_live_s;

    // Saturating or scaling mix of the accumulated voice sum.
    function automatic logic [SAMPLE_W-1:0] mix_sample(input logic signed [ACC_W-1:0] a);
        if (MIX_MODE == 1) begin
            mix_sample = SAMPLE_W'(a >>> LOG2V);
        end else if (a > ACC_W'(S_MAX)) begin
            mix_sample = S_MAX;
        end else if (a < ACC_W'(S_MIN)) begin
            mix_sample = S_MIN;
        end else begin
            mix_sample = a[SAMPLE_W-1:0];
        end
    endfunction

    assign note_ready    = (state_r == IDLE);
    assign frame_start_s = (state_r == IDLE) && new_frame;
    // Out-of-range voice indices are accepted but never written.
    assign load_s        = note_valid && note_ready && ({1'b0, note_voice} < LAST_CNT);

    // Pipeline bookkeeping: cycle k addresses voice k, cycle k+1 accumulates it.
    always_comb begin
        next_cnt_s   = cnt_r + CW'(1);
        rd_idx_s     = VW'(next_cnt_s);
        acc_idx_s    = VW'(cnt_r - CW'(1));
        acc_en_s     = (state_r == RENDER) && (cnt_r != {CW{1'b0}});
        last_s       = (state_r == RENDER) && (cnt_r == LAST_CNT);
        voice_adv_s  = acc_en_s && play && (remain_r[acc_idx_s] != {DUR_W{1'b0}});
        voice_live_s = voice_adv_s && (step_r[acc_idx_s] != {PHASE_W{1'b0}});
        if (voice_live_s) begin
            contrib_s = ACC_W'($signed(rom_data));
        end else begin
            contrib_s = {ACC_W{1'b0}};
        end
        acc_next_s = acc_r + contrib_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (new_frame) begin
                    state_next_s = RENDER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RENDER: begin
                if (last_s) begin
                    state_next_s = OUTPUT;
                end else begin
                    state_next_s = RENDER;
                end
            end
            OUTPUT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Voice counter and mix accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {ACC_W{1'b0}};
        end else if (frame_start_s) begin
            cnt_r <= {CW{1'b0}};
            acc_r <= {ACC_W{1'b0}};
        end else if (state_r == RENDER) begin
            cnt_r <= next_cnt_s;
            acc_r <= acc_next_s;
        end else begin
            cnt_r <= {CW{1'b0}};
            acc_r <= acc_r;
        end
    end

    // Per-voice state: note loads in IDLE, phase/duration advance while accumulating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_r[i]  <= {PHASE_W{1'b0}};
                step_r[i]   <= {PHASE_W{1'b0}};
                remain_r[i] <= {DUR_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (load_s && (note_voice == VW'(i))) begin
                    phase_r[i]  <= {PHASE_W{1'b0}};
                    step_r[i]   <= note_step;
                    remain_r[i] <= note_dur;
                end else if (voice_adv_s && (acc_idx_s == VW'(i))) begin
                    phase_r[i]  <= phase_r[i] + step_r[i];
                    remain_r[i] <= remain_r[i] - DUR_W'(1);
                end else begin
                    phase_r[i]  <= phase_r[i];
                    remain_r[i] <= remain_r[i];
                end
            end
        end
    end

    // ROM address; a note loaded on the frame-start edge into voice 0 is seen at phase 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr <= {ROM_ADDR_W{1'b0}};
        end else if (frame_start_s) begin
            if (load_s && (note_voice == {VW{1'b0}})) begin
                rom_addr <= {ROM_ADDR_W{1'b0}};
            end else begin
                rom_addr <= phase_r[0][PHASE_W-1 -: ROM_ADDR_W];
            end
        end else if ((state_r == RENDER) && (next_cnt_s < LAST_CNT)) begin
            rom_addr <= phase_r[rd_idx_s][PHASE_W-1 -: ROM_ADDR_W];
        end else begin
            rom_addr <= rom_addr;
        end
    end

    // Output sample register, loaded as the last voice is accumulated.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_out   <= {SAMPLE_W{1'b0}};
            sample_valid <= 1'b0;
        end else if (last_s) begin
            sample_out   <= mix_sample(acc_next_s);
            sample_valid <= 1'b1;
        end else begin
            sample_out   <= sample_out;
            sample_valid <= 1'b0;
        end
    end

    // Sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_overrun <= 1'b0;
        end else if (new_frame && (state_r != IDLE)) begin
            frame_overrun <= 1'b1;
        end else begin
            frame_overrun <= frame_overrun;
        end
    end

    // Voice activity decode.
    always_comb begin
        active = {VOICES{1'b0}};
        for (int i = 0; i < VOICES; i++) begin
            active[i] = (remain_r[i] != {DUR_W{1'b0}});
        end
    end

endmodule

// File: tb/tb_poly_chord_synth.sv
// Self-checking bench for poly_chord_synth: one instance per mix mode sharing
// stimulus, table-driven directed vectors, corner sequences and random frames.
module tb_poly_chord_synth;

    logic        clk;
    logic        reset;
    logic        new_frame;
    logic        play;
    logic        note_valid;
    logic [1:0]  note_voice;
    logic [21:0] note_step;
    logic [19:0] note_dur;

    logic        note_ready0, note_ready1;
    logic [9:0]  rom_addr0, rom_addr1;
    logic [15:0] rom_data0, rom_data1;
    logic [15:0] sample_out0, sample_out1;
    logic        sample_valid0, sample_valid1;
    logic [3:0]  active0, active1;
    logic        frame_overrun0, frame_overrun1;

    int n_checks;
    int n_errors;
    int rom_mode;

    longint m_phase [4];
    longint m_step  [4];
    longint m_remain[4];
    int     m_addr  [4];
    int     m_e0, m_e1;
    logic [9:0] cap0[4];
    logic [9:0] cap1[4];

    poly_chord_synth #(.MIX_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .play(play),
        .note_valid(note_valid), .note_ready(note_ready0), .note_voice(note_voice),
        .note_step(note_step), .note_dur(note_dur), .rom_addr(rom_addr0),
        .rom_data(rom_data0), .sample_out(sample_out0), .sample_valid(sample_valid0),
        .active(active0), .frame_overrun(frame_overrun0)
    );

    poly_chord_synth #(.MIX_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .new_frame(new_frame), .play(play),
        .note_valid(note_valid), .note_ready(note_ready1), .note_voice(note_voice),
        .note_step(note_step), .note_dur(note_dur), .rom_addr(rom_addr1),
        .rom_data(rom_data1), .sample_out(sample_out1), .sample_valid(sample_valid1),
        .active(active1), .frame_overrun(frame_overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sine ROM stand-in; mode 0 is the a<<4 ramp, 1/2 force full scale, 3 is a signed ramp.
    function automatic int rom_val(input int mode, input int a);
        int v;
        case (mode)
            0:       v = a * 16;
            1:       v = 32767;
            2:       v = -32768;
            default: begin
                v = a * 64;
                if (v >= 32768) v = v - 65536;
            end
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        rom_data0 <= 16'(rom_val(rom_mode, int'(rom_addr0)));
        rom_data1 <= 16'(rom_val(rom_mode, int'(rom_addr1)));
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int m_active();
        int a = 0;
        for (int v = 0; v < 4; v++) if (m_remain[v] > 0) a |= (1 << v);
        return a;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < 4; v++) begin
            m_phase[v] = 0; m_step[v] = 0; m_remain[v] = 0;
        end
    endtask

    task automatic model_load(input int v, input longint st, input longint du);
        m_phase[v] = 0; m_step[v] = st; m_remain[v] = du;
    endtask

    // One frame of the reference: sum live voices, then advance them.
    task automatic model_frame();
        int sum = 0;
        for (int v = 0; v < 4; v++) begin
            m_addr[v] = int'(m_phase[v] / 4096);
            if (m_remain[v] > 0 && play) begin
                if (m_step[v] != 0) sum += rom_val(rom_mode, m_addr[v]);
                m_phase[v] = (m_phase[v] + m_step[v]) % 4194304;
                m_remain[v]--;
            end
        end
        m_e0 = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
        m_e1 = sum >>> 2;
    endtask

    task automatic load_note(input int v, input logic [21:0] st, input logic [19:0] du);
        chk("note_ready before load", note_ready0, 1);
        note_valid = 1'b1; note_voice = 2'(v); note_step = st; note_dur = du;
        @(posedge clk); #1;
        note_valid = 1'b0;
        model_load(v, st, du);
    endtask

    // Render one frame (optionally with a note load in the same cycle) and check it.
    task automatic run_frame(input bit ld, input int v, input logic [21:0] st, input logic [19:0] du);
        int  n;
        bit  got;
        if (ld) begin
            note_valid = 1'b1; note_voice = 2'(v); note_step = st; note_dur = du;
            model_load(v, st, du);
        end
        model_frame();
        for (int k = 0; k < 4; k++) begin cap0[k] = '1; cap1[k] = '1; end
        new_frame = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0; note_valid = 1'b0;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            if (n < 4) begin cap0[n] = rom_addr0; cap1[n] = rom_addr1; end
            chk("note_ready during render", note_ready0, 0);
            if (sample_valid0) got = 1'b1;
            else begin @(posedge clk); #1; n++; end
        end
        chk("sample_valid latency", n, 5);
        chk("sample_valid mode1 aligned", sample_valid1, 1);
        chk("sample_out mode0", $signed(sample_out0), m_e0);
        chk("sample_out mode1", $signed(sample_out1), m_e1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rom_addr v%0d mode0", k), cap0[k], m_addr[k]);
            chk($sformatf("rom_addr v%0d mode1", k), cap1[k], m_addr[k]);
        end
        @(posedge clk); #1;
        chk("sample_valid one cycle", sample_valid0, 0);
        chk("note_ready after render", note_ready0, 1);
        chk("sample_out held", $signed(sample_out0), m_e0);
        chk("active mode0", active0, m_active());
        chk("active mode1", active1, m_active());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " sample_out0"}, sample_out0, 0);
        chk({tag, " sample_out1"}, sample_out1, 0);
        chk({tag, " sample_valid"}, sample_valid0 | sample_valid1, 0);
        chk({tag, " rom_addr0"}, rom_addr0, 0);
        chk({tag, " rom_addr1"}, rom_addr1, 0);
        chk({tag, " active"}, active0 | active1, 0);
        chk({tag, " frame_overrun"}, frame_overrun0 | frame_overrun1, 0);
        chk({tag, " note_ready"}, note_ready0 & note_ready1, 1);
    endtask

    typedef struct {
        bit ld; int voice; int step; int dur;
        bit fr; bit pl; int rmode; int e0; int e1; int eact;
    } vec_t;

    vec_t tbl[21];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wraps[4];
        int pulses;
        int got_sample;
        n_checks = 0; n_errors = 0; rom_mode = 0;
        reset = 1'b0; new_frame = 1'b0; play = 1'b1; note_valid = 1'b0;
        note_voice = 2'd0; note_step = 22'd0; note_dur = 20'd0;
        model_reset();

        //            ld v  step  dur fr pl rm  e0      e1      act
        tbl[0]  = '{1, 0, 4096, 5, 0, 1, 0, 0,      0,      1};
        tbl[1]  = '{0, 0, 0,    0, 1, 1, 0, 0,      0,      1};
        tbl[2]  = '{0, 0, 0,    0, 1, 1, 0, 16,     4,      1};
        tbl[3]  = '{0, 0, 0,    0, 1, 1, 0, 32,     8,      1};
        tbl[4]  = '{0, 0, 0,    0, 1, 1, 0, 48,     12,     1};
        tbl[5]  = '{0, 0, 0,    0, 1, 1, 0, 64,     16,     0};
        tbl[6]  = '{0, 0, 0,    0, 1, 1, 0, 0,      0,      0};
        tbl[7]  = '{1, 0, 4096, 6, 0, 1, 0, 0,      0,      1};
        tbl[8]  = '{0, 0, 0,    0, 1, 1, 0, 0,      0,      1};
        tbl[9]  = '{0, 0, 0,    0, 1, 1, 0, 16,     4,      1};
        tbl[10] = '{0, 0, 0,    0, 1, 0, 0, 0,      0,      1};
        tbl[11] = '{0, 0, 0,    0, 1, 0, 0, 0,      0,      1};
        tbl[12] = '{0, 0, 0,    0, 1, 0, 0, 0,      0,      1};
        tbl[13] = '{0, 0, 0,    0, 1, 1, 0, 32,     8,      1};
        tbl[14] = '{1, 0, 4096, 2, 0, 1, 0, 0,      0,      1};
        tbl[15] = '{1, 1, 4096, 2, 0, 1, 0, 0,      0,      3};
        tbl[16] = '{1, 2, 4096, 2, 0, 1, 0, 0,      0,      7};
        tbl[17] = '{1, 3, 4096, 2, 0, 1, 0, 0,      0,      15};
        tbl[18] = '{0, 0, 0,    0, 1, 1, 1, 32767,  32767,  15};
        tbl[19] = '{0, 0, 0,    0, 1, 1, 2, -32768, -32768, 0};
        tbl[20] = '{0, 0, 0,    0, 1, 1, 2, 0,      0,      0};

        #3;
        check_reset_state("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_reset_state("after reset");

        for (int r = 0; r < 21; r++) begin
            play = tbl[r].pl;
            rom_mode = tbl[r].rmode;
            if (tbl[r].ld) load_note(tbl[r].voice, 22'(tbl[r].step), 20'(tbl[r].dur));
            if (tbl[r].fr) begin
                run_frame(1'b0, 0, 22'd0, 20'd0);
                chk($sformatf("table row %0d sample mode0", r), $signed(sample_out0), tbl[r].e0);
                chk($sformatf("table row %0d sample mode1", r), $signed(sample_out1), tbl[r].e1);
            end
            chk($sformatf("table row %0d active", r), active0, tbl[r].eact);
        end

        // Load and frame in the same cycle: render must see the new note at phase 0.
        play = 1'b1; rom_mode = 0;
        run_frame(1'b1, 0, 22'd4096, 20'd3);
        chk("same-cycle load addr", cap0[0], 0);
        chk("same-cycle load sample", $signed(sample_out0), 0);

        // Phase wrap on voice 1.
        load_note(1, 22'd2097152, 20'd4);
        wraps = '{0, 512, 0, 512};
        for (int f = 0; f < 4; f++) begin
            run_frame(1'b0, 0, 22'd0, 20'd0);
            chk($sformatf("phase wrap frame %0d addr", f), cap0[1], wraps[f]);
        end
        chk("voice1 done after wrap", active0[1], 0);

        // Second new_frame mid-render: sticky overrun, no extra sample.
        chk("overrun clear before", frame_overrun0, 0);
        load_note(2, 22'd8192, 20'd9);
        model_frame();
        new_frame = 1'b1;
        @(posedge clk); #1; new_frame = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; new_frame = 1'b1;
        pulses = 0; got_sample = 0;
        for (int c = 0; c < 15; c++) begin
            if (sample_valid0) begin pulses++; got_sample = $signed(sample_out0); end
            @(posedge clk); #1; new_frame = 1'b0;
        end
        chk("overrun sample count", pulses, 1);
        chk("overrun sample value", got_sample, m_e0);
        chk("frame_overrun mode0", frame_overrun0, 1);
        chk("frame_overrun mode1", frame_overrun1, 1);
        chk("note_ready after overrun", note_ready0, 1);

        // Reset in the middle of a render.
        new_frame = 1'b1;
        @(posedge clk); #1; new_frame = 1'b0;
        @(posedge clk); #4;
        reset = 1'b0;
        #1;
        check_reset_state("mid-render reset");
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            if (sample_valid0 | sample_valid1) pulses++;
            @(posedge clk); #1;
        end
        chk("no sample after reset", pulses, 0);
        check_reset_state("after mid-render reset");

        // Random notes, play and ROM contents against the reference model.
        for (int it = 0; it < 60; it++) begin
            int nl;
            logic [21:0] st;
            rom_mode = $urandom_range(0, 3);
            play = ($urandom_range(0, 4) != 0);
            nl = $urandom_range(0, 2);
            for (int j = 0; j < nl; j++) begin
                st = ($urandom_range(0, 5) == 0) ? 22'd0 : 22'($urandom());
                load_note($urandom_range(0, 3), st, 20'($urandom_range(0, 8)));
            end
            st = ($urandom_range(0, 5) == 0) ? 22'd0 : 22'($urandom());
            if ($urandom_range(0, 3) == 0)
                run_frame(1'b1, $urandom_range(0, 3), st, 20'($urandom_range(0, 8)));
            else
                run_frame(1'b0, 0, 22'd0, 20'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
